// File: rtl/spi_xip_pkg.sv
// Shared types and constants for the SPI execute-in-place bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_xip_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PASS,
        ST_WR_TX1,
        ST_WR_TX0,
        ST_WR_DIV,
        ST_WR_SS,
        ST_WR_CTRL,
        ST_POLL,
        ST_RD_RX,
        ST_CLR_SS,
        ST_RESP
    } state_t;

    // SPI master register offsets
    localparam logic [4:0] SPI_RX0     = 5'h00;
    localparam logic [4:0] SPI_TX0     = 5'h00;
    localparam logic [4:0] SPI_TX1     = 5'h04;
    localparam logic [4:0] SPI_CTRL    = 5'h10;
    localparam logic [4:0] SPI_DIVIDER = 5'h14;
    localparam logic [4:0] SPI_SS      = 5'h18;

    localparam int          CTRL_GO_BIT    = 8;
    // 64-bit transfer, data changes on falling edge, auto slave-select, GO
    localparam logic [31:0] XIP_CTRL_VAL   = 32'h0000_2540;
    localparam logic [7:0]  FLASH_READ_CMD = 8'h03;

    // Flash returns the first byte in the top lane; APB wants it in the bottom lane
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/spi_xip_ctrl_if.sv
// APB slave request/response plus Wishbone register-port request/response.
// Latency: n/a (wiring only).
// Backpressure: APB via in_pready, Wishbone via wb_ack_i.
interface spi_xip_ctrl_if;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;

    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    // bridge side: APB slave, Wishbone master
    modport slave (
        input  in_paddr, in_psel, in_penable, in_pwrite, in_pwdata, in_pstrb,
        output in_pready, in_prdata, in_pslverr,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    // environment side: APB master, Wishbone slave
    modport master (
        output in_paddr, in_psel, in_penable, in_pwrite, in_pwdata, in_pstrb,
        input  in_pready, in_prdata, in_pslverr,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/spi_xip_ctrl.sv
// APB-to-SPI-master bridge: pass-through register access, or memory-mapped flash read (XIP).
// Latency: pass-through = 1 + wb access + 1; XIP read = 8 wb accesses (+ extra polls) each with a gap cycle.
// Backpressure: in_pready held low until done; every wb access stalls until wb_ack_i, no timeout.
module spi_xip_ctrl
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] flash_addr_start = 32'h3000_0000,
    parameter logic [31:0] flash_addr_end   = 32'h3fff_ffff,
    parameter logic [31:0] xip_divider      = 32'h0000_0001
) (
    input  logic           clk,
    input  logic           reset,
    spi_xip_ctrl_if.slave  bus
);

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic        write_q, write_d;
    logic [31:0] rx_q, rx_d;

    logic [4:0]  wb_adr_q, wb_adr_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic [3:0]  wb_sel_q, wb_sel_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_stb_q, wb_stb_d;

    logic        pready_q, pready_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;

    logic        req_xip;
    logic [4:0]  acc_adr;
    logic [31:0] acc_dat;
    logic        acc_we;
    logic [3:0]  acc_sel;

    assign req_xip = (bus.in_paddr >= flash_addr_start) && (bus.in_paddr <= flash_addr_end);

    // Downstream access implied by the current state
    always_comb begin
        acc_adr = SPI_TX0;
        acc_dat = '0;
        acc_we  = 1'b1;
        acc_sel = 4'hf;
        case (state_q)
            ST_PASS: begin
                acc_adr = addr_q[4:0];
                acc_dat = wdata_q;
                acc_we  = write_q;
                acc_sel = strb_q;
            end
            ST_WR_TX1:  begin acc_adr = SPI_TX1;     acc_dat = {FLASH_READ_CMD, addr_q}; end
            ST_WR_TX0:  begin acc_adr = SPI_TX0;     acc_dat = '0;                       end
            ST_WR_DIV:  begin acc_adr = SPI_DIVIDER; acc_dat = xip_divider;              end
            ST_WR_SS:   begin acc_adr = SPI_SS;      acc_dat = 32'd1;                    end
            ST_WR_CTRL: begin acc_adr = SPI_CTRL;    acc_dat = XIP_CTRL_VAL;             end
            ST_POLL:    begin acc_adr = SPI_CTRL;    acc_we  = 1'b0;                     end
            ST_RD_RX:   begin acc_adr = SPI_RX0;     acc_we  = 1'b0;                     end
            ST_CLR_SS:  begin acc_adr = SPI_SS;      acc_dat = '0;                       end
            default: ;
        endcase
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        write_d   = write_q;
        rx_d      = rx_q;
        wb_adr_d  = wb_adr_q;
        wb_dat_d  = wb_dat_q;
        wb_sel_d  = wb_sel_q;
        wb_we_d   = wb_we_q;
        wb_stb_d  = wb_stb_q;
        // APB response is only presented during the single RESP cycle
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_psel && bus.in_penable) begin
                    addr_d  = bus.in_paddr[23:0];
                    wdata_d = bus.in_pwdata;
                    strb_d  = bus.in_pstrb;
                    write_d = bus.in_pwrite;
                    if (req_xip && bus.in_pwrite) begin
                        // flash is read-only through this window
                        state_d   = ST_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else if (req_xip) begin
                        state_d = ST_WR_TX1;
                    end else begin
                        state_d = ST_PASS;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: begin
                if (!wb_stb_q) begin
                    // launch after at least one idle cycle; fields then frozen until ack
                    wb_stb_d = 1'b1;
                    wb_adr_d = acc_adr;
                    wb_dat_d = acc_dat;
                    wb_we_d  = acc_we;
                    wb_sel_d = acc_sel;
                end else if (bus.wb_ack_i) begin
                    wb_stb_d = 1'b0;
                    case (state_q)
                        ST_PASS: begin
                            state_d  = ST_RESP;
                            pready_d = 1'b1;
                            prdata_d = write_q ? 32'd0 : bus.wb_dat_i;
                        end
                        ST_WR_TX1:  state_d = ST_WR_TX0;
                        ST_WR_TX0:  state_d = ST_WR_DIV;
                        ST_WR_DIV:  state_d = ST_WR_SS;
                        ST_WR_SS:   state_d = ST_WR_CTRL;
                        ST_WR_CTRL: state_d = ST_POLL;
                        ST_POLL: begin
                            if (!bus.wb_dat_i[CTRL_GO_BIT]) state_d = ST_RD_RX;
                        end
                        ST_RD_RX: begin
                            rx_d    = byte_swap(bus.wb_dat_i);
                            state_d = ST_CLR_SS;
                        end
                        ST_CLR_SS: begin
                            state_d  = ST_RESP;
                            pready_d = 1'b1;
                            prdata_d = rx_q;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            write_q   <= 1'b0;
            rx_q      <= '0;
            wb_adr_q  <= '0;
            wb_dat_q  <= '0;
            wb_sel_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_stb_q  <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            write_q   <= write_d;
            rx_q      <= rx_d;
            wb_adr_q  <= wb_adr_d;
            wb_dat_q  <= wb_dat_d;
            wb_sel_q  <= wb_sel_d;
            wb_we_q   <= wb_we_d;
            wb_stb_q  <= wb_stb_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign bus.wb_adr_o   = wb_adr_q;
    assign bus.wb_dat_o   = wb_dat_q;
    assign bus.wb_sel_o   = wb_sel_q;
    assign bus.wb_we_o    = wb_we_q;
    assign bus.wb_stb_o   = wb_stb_q;
    assign bus.wb_cyc_o   = wb_stb_q;
    assign bus.in_pready  = pready_q;
    assign bus.in_prdata  = prdata_q;
    assign bus.in_pslverr = pslverr_q;

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Bench for spi_xip_ctrl: APB driver, behavioural SPI register model, access/response scoreboard.
// Latency: n/a.
// Backpressure: Wishbone acks delayed randomly (0..3) or by a fixed count.
module tb_spi_xip_ctrl;

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } acc_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_xip_ctrl_if bus ();

    spi_xip_ctrl #(
        .flash_addr_start (32'h3000_0000),
        .flash_addr_end   (32'h3fff_ffff),
        .xip_divider      (32'h0000_0001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    acc_t        exp_q[$];
    acc_t        log_q[$];
    int          ack_delay_fix = -1;
    logic        in_xip = 1'b0;
    int          cfg_poll_n = 0;
    logic [31:0] rx_val = '0;
    logic [31:0] pass_rdata = '0;
    int          ctrl_reads = 0;
    int          n_access = 0;
    logic        resp_armed = 1'b0;
    logic        resp_seen = 1'b0;
    logic [31:0] exp_prdata = '0;
    logic        exp_err = 1'b0;
    logic [31:0] last_prdata = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic acc_t mk(input logic [4:0] adr, input logic [31:0] dat,
                                input logic we, input logic [3:0] sel);
        acc_t a;
        a.adr = adr; a.dat = dat; a.we = we; a.sel = sel;
        return a;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stb"},    32'(bus.wb_stb_o),   0);
        chk({tag, "_cyc"},    32'(bus.wb_cyc_o),   0);
        chk({tag, "_we"},     32'(bus.wb_we_o),    0);
        chk({tag, "_adr"},    32'(bus.wb_adr_o),   0);
        chk({tag, "_dat"},    bus.wb_dat_o,        0);
        chk({tag, "_sel"},    32'(bus.wb_sel_o),   0);
        chk({tag, "_pready"}, 32'(bus.in_pready),  0);
        chk({tag, "_prdata"}, bus.in_prdata,       0);
        chk({tag, "_pslverr"},32'(bus.in_pslverr), 0);
    endtask

    // SPI register model + Wishbone responder + per-cycle output checker
    initial begin
        acc_t        cur;
        acc_t        e;
        int          wait_cnt;
        int          dly;
        int          busy_left;
        bit          prev_stb;
        logic [31:0] rsp;
        wait_cnt = 0; dly = 0; busy_left = 0; prev_stb = 0;
        cur = mk(0, 0, 0, 0);
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.wb_ack_i = 1'b0;
                bus.wb_dat_i = '0;
                prev_stb = 0;
                wait_cnt = 0;
            end else begin
                if (bus.wb_ack_i) begin
                    bus.wb_ack_i = 1'b0;
                    bus.wb_dat_i = '0;
                    chk("wb_gap_after_ack", 32'(bus.wb_stb_o), 0);
                    prev_stb = 0;
                end else if (bus.wb_stb_o) begin
                    chk("wb_cyc_with_stb", 32'(bus.wb_cyc_o), 1);
                    if (!prev_stb) begin
                        cur = mk(bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o, bus.wb_sel_o);
                        wait_cnt = 0;
                        dly = (ack_delay_fix >= 0) ? ack_delay_fix : int'($urandom_range(0, 3));
                        n_access++;
                    end else begin
                        chk("wb_stable_adr", 32'(bus.wb_adr_o), 32'(cur.adr));
                        chk("wb_stable_dat", bus.wb_dat_o, cur.dat);
                        chk("wb_stable_we",  32'(bus.wb_we_o),  32'(cur.we));
                        chk("wb_stable_sel", 32'(bus.wb_sel_o), 32'(cur.sel));
                    end
                    prev_stb = 1;
                    if (wait_cnt == dly) begin
                        log_q.push_back(cur);
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL wb_unexpected: got access adr %h we %0d, expected none", cur.adr, cur.we);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wb_adr", 32'(cur.adr), 32'(e.adr));
                            chk("wb_we",  32'(cur.we),  32'(e.we));
                            chk("wb_sel", 32'(cur.sel), 32'(e.sel));
                            if (e.we) chk("wb_wdat", cur.dat, e.dat);
                        end
                        if (cur.we) begin
                            rsp = $urandom();
                            if (in_xip && cur.adr == 5'h10 && cur.dat[8]) begin
                                busy_left  = cfg_poll_n;
                                ctrl_reads = 0;
                            end
                        end else if (!in_xip) begin
                            rsp = pass_rdata;
                        end else if (cur.adr == 5'h10) begin
                            ctrl_reads++;
                            rsp = $urandom() & 32'hffff_feff;
                            if (busy_left > 0) begin
                                rsp = rsp | 32'h0000_0100;
                                busy_left--;
                            end
                        end else begin
                            rsp = rx_val;
                        end
                        bus.wb_dat_i = rsp;
                        bus.wb_ack_i = 1'b1;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    chk("wb_cyc_idle", 32'(bus.wb_cyc_o), 0);
                end

                if (bus.in_pready) begin
                    if (!resp_armed) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL pready_unexpected: got pready=1, expected 0 (t=%0t)", $time);
                    end else begin
                        chk("prdata",  bus.in_prdata, exp_prdata);
                        chk("pslverr", 32'(bus.in_pslverr), 32'(exp_err));
                        last_prdata = bus.in_prdata;
                        last_err    = bus.in_pslverr;
                        resp_armed  = 1'b0;
                        resp_seen   = 1'b1;
                    end
                end
            end
        end
    end

    // Reference model for one APB transfer, then drive setup+access phases
    task automatic apb_start(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input bit write,
                             input int poll_n, input logic [31:0] rx);
        bit xip;
        xip = (addr >= 32'h3000_0000) && (addr <= 32'h3fff_ffff);
        in_xip     = xip;
        cfg_poll_n = poll_n;
        rx_val     = rx;
        pass_rdata = $urandom();
        exp_q.delete();
        log_q.delete();
        if (xip && write) begin
            exp_prdata = 0;
            exp_err    = 1;
        end else if (xip) begin
            exp_q.push_back(mk(5'h04, {8'h03, addr[23:0]}, 1, 4'hf));
            exp_q.push_back(mk(5'h00, 32'h0, 1, 4'hf));
            exp_q.push_back(mk(5'h14, 32'h1, 1, 4'hf));
            exp_q.push_back(mk(5'h18, 32'h1, 1, 4'hf));
            exp_q.push_back(mk(5'h10, 32'h2540, 1, 4'hf));
            for (int i = 0; i <= poll_n; i++) exp_q.push_back(mk(5'h10, 0, 0, 4'hf));
            exp_q.push_back(mk(5'h00, 0, 0, 4'hf));
            exp_q.push_back(mk(5'h18, 32'h0, 1, 4'hf));
            exp_prdata = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
            exp_err    = 0;
        end else begin
            exp_q.push_back(mk(addr[4:0], wdata, write, strb));
            exp_prdata = write ? 32'h0 : pass_rdata;
            exp_err    = 0;
        end
        resp_seen  = 1'b0;
        resp_armed = 1'b1;
        @(posedge clk); #1;
        bus.in_paddr   = addr;
        bus.in_pwdata  = wdata;
        bus.in_pstrb   = strb;
        bus.in_pwrite  = write;
        bus.in_psel    = 1'b1;
        bus.in_penable = 1'b0;
        @(posedge clk); #1;
        bus.in_penable = 1'b1;
    endtask

    task automatic apb_finish();
        int cyc;
        cyc = 0;
        while (!resp_seen && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        bus.in_psel    = 1'b0;
        bus.in_penable = 1'b0;
        if (!resp_seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL apb_timeout: got no pready in %0d cycles, expected one", cyc);
            resp_armed = 1'b0;
        end
        chk("wb_accesses_missing", 32'(exp_q.size()), 0);
    endtask

    task automatic apb(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit write,
                       input int poll_n, input logic [31:0] rx);
        apb_start(addr, wdata, strb, write, poll_n, rx);
        apb_finish();
    endtask

    initial begin
        int          n0;
        int          cyc;
        int          kind;
        logic [31:0] a;
        reset = 1'b1;
        bus.in_paddr = '0; bus.in_psel = 1'b0; bus.in_penable = 1'b0;
        bus.in_pwrite = 1'b0; bus.in_pwdata = '0; bus.in_pstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // flash read: full sequence, byte-swapped data
        apb(32'h3000_0100, 0, 4'h0, 0, 0, 32'h4433_2211);
        chk("rd_log_len", 32'(log_q.size()), 8);
        if (log_q.size() > 0) chk("rd_tx1_literal", log_q[0].dat, 32'h0300_0100);
        chk("rd_prdata_literal", last_prdata, 32'h1122_3344);
        chk("rd_err_literal", 32'(last_err), 0);

        // GO busy three times
        apb(32'h3123_4568, 0, 4'h0, 0, 3, 32'hcafe_f00d);
        chk("poll_ctrl_reads", 32'(ctrl_reads), 4);
        chk("poll_prdata_literal", last_prdata, 32'h0df0_feca);

        // flash write rejected without downstream traffic
        n0 = n_access;
        apb(32'h3000_0000, 32'h1234_5678, 4'hf, 1, 0, 0);
        chk("xipwr_no_access", 32'(n_access - n0), 0);
        chk("xipwr_err", 32'(last_err), 1);
        chk("xipwr_prdata", last_prdata, 0);

        // pass-through write
        apb(32'h1000_1014, 32'h5, 4'hf, 1, 0, 0);
        chk("pass_log_len", 32'(log_q.size()), 1);
        if (log_q.size() > 0) chk("pass_adr_literal", 32'(log_q[0].adr), 32'h14);
        if (log_q.size() > 0) chk("pass_dat_literal", log_q[0].dat, 32'h5);
        chk("pass_err", 32'(last_err), 0);

        // reset while polling
        apb_start(32'h3000_0040, 0, 4'h0, 0, 50, 32'hdead_beef);
        cyc = 0;
        while (ctrl_reads < 2 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        if (ctrl_reads < 2) begin
            n_tests++;
            n_fail++;
            $display("FAIL poll_reach_timeout: got %0d ctrl reads, expected 2", ctrl_reads);
        end
        #2;
        reset = 1'b1;
        bus.in_psel = 1'b0;
        bus.in_penable = 1'b0;
        resp_armed = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        apb(32'h3fff_ffff, 0, 4'h0, 0, 1, 32'h0102_0304);
        if (log_q.size() > 0) chk("post_reset_tx1", log_q[0].dat, 32'h03ff_ffff);
        chk("post_reset_prdata", last_prdata, 32'h0403_0201);

        // long stalls on every access
        ack_delay_fix = 4;
        apb(32'h3abc_def0, 0, 4'h0, 0, 2, 32'h8899_aabb);
        apb(32'h2000_0008, 0, 4'h0, 0, 0, 0);
        apb(32'h4000_0018, 32'ha5a5_5a5a, 4'h3, 1, 0, 0);
        ack_delay_fix = -1;

        // randomized mix
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            if (kind < 2) begin
                a = 32'h3000_0000 | ($urandom() & 32'h0fff_ffff);
            end else begin
                a = $urandom();
                if (a >= 32'h3000_0000 && a <= 32'h3fff_ffff) a = a ^ 32'h4000_0000;
            end
            if (kind == 1 || kind == 3)
                apb(a, $urandom(), 4'($urandom_range(1, 15)), 1, 0, 0);
            else
                apb(a, 0, 4'h0, 0, int'($urandom_range(0, 3)), $urandom());
            repeat (int'($urandom_range(0, 2))) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_xip_ctrl.md
SPI_XIP_CTRL -- requirements
Module: spi_xip_ctrl

Interface
REQ-001 Parameter flash_addr_start, default 32'h30000000, meaning lowest XIP-mapped address.
REQ-002 Parameter flash_addr_end, default 32'h3fffffff, meaning highest XIP-mapped address.
REQ-003 Parameter xip_divider, default 32'h0000_0001, meaning the SPI DIVIDER value used for XIP reads.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_paddr/in_psel/in_penable/in_pwrite/in_pwdata[31:0]/in_pstrb[3:0]  in  APB slave request.
REQ-007 in_pready/in_prdata[31:0]/in_pslverr  out  APB slave response.
REQ-008 wb_adr_o[4:0]/wb_dat_o[31:0]/wb_sel_o[3:0]/wb_we_o/wb_stb_o/wb_cyc_o  out  request to SPI master register port.
REQ-009 wb_dat_i[31:0]/wb_ack_i  in  SPI master register response.

Function
REQ-010 Address in [flash_addr_start, flash_addr_end] SHALL select XIP; any other address SHALL select pass-through.
REQ-011 FSM states: IDLE, PASS, WR_TX1, WR_TX0, WR_DIV, WR_SS, WR_CTRL, POLL, RD_RX, CLR_SS, RESP.
REQ-012 IDLE accepts a request only when in_psel&in_penable; the request is latched (addr, data, strb, write) that cycle.
REQ-013 Pass-through: PASS drives wb_adr_o=in_paddr[4:0], other fields from the latch; on wb_ack_i go to RESP with wb_dat_i captured.
REQ-014 XIP write SHALL issue no downstream access; go directly to RESP with in_pslverr=1.
REQ-015 XIP read sequence, one downstream write each: WR_TX1 addr 0x04 data {8'h03, addr[23:0]}; WR_TX0 addr 0x00 data 0; WR_DIV addr 0x14 data xip_divider; WR_SS addr 0x18 data 1; WR_CTRL addr 0x10 data 32'h0000_2540 (len 64, TX_NEG, ASS, GO).
REQ-016 POLL reads addr 0x10 repeatedly; leave when returned bit 8 (GO) is 0, else reissue.
REQ-017 RD_RX reads addr 0x00; captured data is stored byte-swapped: {d[7:0],d[15:8],d[23:16],d[31:24]}.
REQ-018 CLR_SS writes addr 0x18 data 0, then RESP.
REQ-019 Every downstream access: wb_stb_o=wb_cyc_o=1 held with stable fields until the cycle wb_ack_i=1; deassert the following cycle (one idle cycle between accesses); wb_sel_o=4'hf for all XIP accesses.
REQ-020 RESP asserts in_pready=1 for exactly one cycle with in_prdata and in_pslverr valid, then IDLE; in_pready=0 in all other states.
REQ-021 In_prdata SHALL be 0 in RESP for writes and errored accesses.
REQ-022 New APB requests arriving while not IDLE are not accepted (APB holds them by protocol).
REQ-023 No timeout: POLL waits indefinitely.

Reset
REQ-024 On reset: state IDLE, all wb_* outputs 0, in_pready=0, in_prdata=0, in_pslverr=0, latches 0.
REQ-025 Reset mid-sequence SHALL abort immediately with no further downstream access; SS is not restored by this block.

Structure
REQ-026 Shared package spi_xip_pkg holds the state enum, SPI register offsets (RX0/TX0 0x00, TX1 0x04, CTRL 0x10, DIVIDER 0x14, SS 0x18), CTRL_GO_BIT=8, XIP_CTRL_VAL, and FLASH_READ_CMD=8'h03.
REQ-027 Single module; no sub-module (a downstream access helper is optional, not required).

Verification
REQ-028 APB read 0x30000100, model SPI returns RX0=32'h44332211 -> downstream writes TX1=32'h03000100, TX0=0, DIV=1, SS=1, CTRL=32'h2540, polls, reads RX0, SS=0; in_prdata=32'h11223344, pslverr=0.
REQ-029 POLL returning GO=1 three times then 0 -> exactly four CTRL reads before RX0 read.
REQ-030 APB write 0x30000000 -> zero wb_stb_o cycles, in_pready one cycle, in_pslverr=1.
REQ-031 APB write 0x10001014 data 5 -> one wb write addr 0x14 data 5, in_pready after wb_ack_i, pslverr=0.
REQ-032 Reset asserted during POLL -> next cycle all outputs 0, state IDLE; subsequent read 0x3fffffff completes normally with TX1=32'h03ffffff.
REQ-033 wb_ack_i delayed 4 cycles on each access -> wb fields stable throughout every stall.
